proc_frame_ctrl: RTL and testbench

Frame sequencer for the pixel processing datapath. It sits between the read side of the async FIFO, the pixel processor, and a register or config master. It latches mode and kernel configuration and applies it only at frame boundaries. At each frame start it pulses the processor's reset so line buffers and the priming count restart. It gates exactly FRAME_PIXELS input beats per frame, counts output beats, and reports frame completion, drain timeout and overrun.

---
 rtl/proc_frame_ctrl.sv | 108 ++++++++++
 tb/tb_proc_frame_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/proc_frame_ctrl.sv
// proc_frame_ctrl: frame sequencer gating pixel input beats, counting outputs and applying config at frame boundaries
module proc_frame_ctrl #(
  parameter int FRAME_PIXELS    = 4096,
  parameter int CONV_PRIME      = 2051,
  parameter int PROC_RST_CYCLES = 2,
  parameter int DRAIN_TIMEOUT   = 256,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_mode,
  input  logic [71:0]      cfg_kernel,
  input  logic             src_valid,
  output logic             src_rd,
  input  logic             proc_ready,
  output logic             proc_valid_in,
  input  logic             proc_valid_out,
  input  logic             sink_ready,
  output logic             proc_rstn,
  output logic [1:0]       proc_mode,
  output logic [71:0]      proc_kernel,
  output logic             busy,
  output logic             frame_done,
  output logic             error,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] in_cnt,
  output logic [CNT_W-1:0] out_cnt
);
  typedef enum logic [2:0] {IDLE, RST_PROC, STREAM, DRAIN, DONE, FLUSH} state_t;
  localparam int RW = $clog2(PROC_RST_CYCLES + 1);
  localparam int SW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FULL_E = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] CONV_E = CNT_W'(FRAME_PIXELS > CONV_PRIME ? FRAME_PIXELS - CONV_PRIME : 0);
  state_t state, state_nx;
  logic [RW-1:0] rst_cnt;
  logic [SW-1:0] sil_cnt, sil_nx;
  logic [1:0] sh_mode;
  logic [71:0] sh_kernel;
  logic [CNT_W-1:0] exp_out;
  logic beat, go, rst_done, in_last, timeout, abort_ok;
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  // datapath handshakes and next-state selection; abort overrides any same-cycle completion
  always_comb begin
    exp_out = proc_mode == 2'b10 ? CONV_E : FULL_E;
    beat = proc_valid_out && sink_ready && (state == STREAM || state == DRAIN);
    proc_valid_in = state == STREAM && src_valid && in_cnt < FULL_E;
    src_rd = proc_valid_in && proc_ready;
    go = state == IDLE && start;
    rst_done = rst_cnt == RW'(PROC_RST_CYCLES - 1);
    in_last = src_rd && in_cnt == FULL_E - 1'b1;
    sil_nx = beat ? '0 : sil_cnt + 1'b1;
    timeout = sil_nx == SW'(DRAIN_TIMEOUT);
    abort_ok = abort && (state == RST_PROC || state == STREAM || state == DRAIN);
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = start ? RST_PROC : IDLE;
      RST_PROC: state_nx = rst_done ? STREAM : RST_PROC;
      STREAM:   state_nx = in_last ? DRAIN : STREAM;
      DRAIN:    state_nx = out_cnt == exp_out ? DONE : timeout ? IDLE : DRAIN;
      DONE:     state_nx = IDLE;
      FLUSH:    state_nx = rst_done ? IDLE : FLUSH;
      default:  state_nx = IDLE;
    endcase
    state_nx = abort_ok ? FLUSH : state_nx;
  end
  // state, processor reset, config shadow/active copies and frame counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      proc_rstn   <= 1'b1;
      rst_cnt     <= '0;
      sil_cnt     <= '0;
      sh_mode     <= '0;
      sh_kernel   <= '0;
      proc_mode   <= '0;
      proc_kernel <= '0;
      error       <= 1'b0;
      frame_cnt   <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
    end else begin
      state     <= state_nx;
      proc_rstn <= !(state_nx == RST_PROC || state_nx == FLUSH);
      rst_cnt   <= (state_nx == state && (state == RST_PROC || state == FLUSH)) ? rst_cnt + 1'b1 : '0;
      sil_cnt   <= state == DRAIN ? sil_nx : '0;
      if (cfg_wr) begin
        sh_mode   <= cfg_mode;
        sh_kernel <= cfg_kernel;
      end
      if (go) begin
        proc_mode   <= cfg_wr ? cfg_mode : sh_mode;
        proc_kernel <= cfg_wr ? cfg_kernel : sh_kernel;
        in_cnt      <= '0;
        out_cnt     <= '0;
        error       <= 1'b0;
      end else begin
        if (src_rd) in_cnt <= in_cnt + 1'b1;
        if (beat && out_cnt != exp_out) out_cnt <= out_cnt + 1'b1;
        if ((beat && out_cnt == exp_out) || (state == DRAIN && state_nx == IDLE)) error <= 1'b1;
      end
      if (state == DONE) frame_cnt <= frame_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_proc_frame_ctrl.sv
// tb_proc_frame_ctrl: directed frame scenarios against proc_frame_ctrl with a stub pixel processor
module tb_proc_frame_ctrl;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst, start, abort, cfg_wr, src_valid, src_rd, proc_ready, proc_valid_in, proc_valid_out;
  logic sink_ready, proc_rstn, busy, frame_done, error;
  logic [1:0] cfg_mode, proc_mode;
  logic [71:0] cfg_kernel, proc_kernel;
  logic [15:0] frame_cnt;
  logic [CW-1:0] in_cnt, out_cnt;
  int n_vec = 0, n_err = 0;
  int n_rd = 0, n_rl = 0, n_done = 0, n_bad = 0, n_drain = 0;
  int pend = 0, nrd = 0;
  int s_rd, s_rl, s_done, s_bad, s_drain;
  always #5 clk = ~clk;
  proc_frame_ctrl #(
    .FRAME_PIXELS(16), .CONV_PRIME(5), .PROC_RST_CYCLES(2), .DRAIN_TIMEOUT(8), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .cfg_kernel(cfg_kernel), .src_valid(src_valid), .src_rd(src_rd), .proc_ready(proc_ready),
    .proc_valid_in(proc_valid_in), .proc_valid_out(proc_valid_out), .sink_ready(sink_ready),
    .proc_rstn(proc_rstn), .proc_mode(proc_mode), .proc_kernel(proc_kernel), .busy(busy),
    .frame_done(frame_done), .error(error), .frame_cnt(frame_cnt), .in_cnt(in_cnt), .out_cnt(out_cnt)
  );
  // stub processor: one output per read, conv mode swallows the first 5 reads
  assign proc_valid_out = pend != 0;
  always @(posedge clk) begin
    if (rst || !proc_rstn) begin
      pend <= 0;
      nrd  <= 0;
    end else begin
      if (src_rd) nrd <= nrd + 1;
      pend <= pend + ((src_rd && (proc_mode != 2'b10 || nrd >= 5)) ? 1 : 0) - ((proc_valid_out && sink_ready) ? 1 : 0);
    end
  end
  // per-cycle event tallies taken mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (src_rd) n_rd++;
      if (!proc_rstn) n_rl++;
      if (frame_done) n_done++;
      if (src_rd && !proc_ready) n_bad++;
      if (busy && in_cnt == 16'd16) n_drain++;
    end
  end
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic snap;
    s_rd = n_rd; s_rl = n_rl; s_done = n_done; s_bad = n_bad; s_drain = n_drain;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    cfg_wr = 1'b0;
  endtask
  task automatic wait_idle(input int lim, input bit bp);
    for (int i = 0; i < lim && busy; i++) begin
      if (bp) begin
        proc_ready = i[0];
        src_valid = (i % 5) != 3;
      end
      tick;
    end
    chk("idle", 72'(busy), 72'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_wr = 1'b0; cfg_mode = 2'b00; cfg_kernel = '0;
    src_valid = 1'b0; proc_ready = 1'b0; sink_ready = 1'b0;
    repeat (3) tick;
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_rstn", 72'(proc_rstn), 72'(1));
    chk("rst_frames", 72'(frame_cnt), 72'(0));
    chk("rst_mode", 72'(proc_mode), 72'(0));
    chk("rst_kernel", proc_kernel, 72'(0));
    chk("rst_error", 72'(error), 72'(0));
    rst = 1'b0;
    src_valid = 1'b1; proc_ready = 1'b1; sink_ready = 1'b1;
    tick;
    snap;
    cfg_wr = 1'b1; cfg_mode = 2'b00;
    pulse_start;
    wait_idle(100, 1'b0);
    chk("pass_rstn_low", 72'(n_rl - s_rl), 72'(2));
    chk("pass_reads", 72'(n_rd - s_rd), 72'(16));
    chk("pass_in_cnt", 72'(in_cnt), 72'(16));
    chk("pass_out_cnt", 72'(out_cnt), 72'(16));
    chk("pass_done", 72'(n_done - s_done), 72'(1));
    chk("pass_frames", 72'(frame_cnt), 72'(1));
    chk("pass_error", 72'(error), 72'(0));
    snap;
    cfg_wr = 1'b1; cfg_mode = 2'b10; cfg_kernel = {9{8'h01}};
    pulse_start;
    chk("conv_mode", 72'(proc_mode), 72'(2));
    chk("conv_kernel", proc_kernel, {9{8'h01}});
    wait_idle(100, 1'b0);
    chk("conv_out_cnt", 72'(out_cnt), 72'(11));
    chk("conv_done", 72'(n_done - s_done), 72'(1));
    chk("conv_frames", 72'(frame_cnt), 72'(2));
    chk("conv_error", 72'(error), 72'(0));
    snap;
    cfg_wr = 1'b1; cfg_mode = 2'b00;
    pulse_start;
    wait_idle(300, 1'b1);
    proc_ready = 1'b1; src_valid = 1'b1;
    chk("bp_bad_reads", 72'(n_bad - s_bad), 72'(0));
    chk("bp_reads", 72'(n_rd - s_rd), 72'(16));
    chk("bp_in_cnt", 72'(in_cnt), 72'(16));
    chk("bp_out_cnt", 72'(out_cnt), 72'(16));
    chk("bp_frames", 72'(frame_cnt), 72'(3));
    pulse_start;
    repeat (5) tick;
    cfg_wr = 1'b1; cfg_mode = 2'b01;
    tick;
    cfg_wr = 1'b0;
    chk("shadow_mid_mode", 72'(proc_mode), 72'(0));
    wait_idle(100, 1'b0);
    chk("shadow_end_mode", 72'(proc_mode), 72'(0));
    chk("shadow_frames1", 72'(frame_cnt), 72'(4));
    pulse_start;
    chk("shadow_new_mode", 72'(proc_mode), 72'(1));
    wait_idle(100, 1'b0);
    chk("inv_out_cnt", 72'(out_cnt), 72'(16));
    chk("shadow_frames2", 72'(frame_cnt), 72'(5));
    snap;
    sink_ready = 1'b0;
    pulse_start;
    wait_idle(100, 1'b0);
    chk("to_error", 72'(error), 72'(1));
    chk("to_done", 72'(n_done - s_done), 72'(0));
    chk("to_frames", 72'(frame_cnt), 72'(5));
    chk("to_drain_cycles", 72'(n_drain - s_drain), 72'(8));
    chk("to_out_cnt", 72'(out_cnt), 72'(0));
    sink_ready = 1'b1;
    repeat (3) tick;
    chk("to_sticky", 72'(error), 72'(1));
    snap;
    pulse_start;
    chk("ab_err_clr", 72'(error), 72'(0));
    for (int i = 0; i < 50 && in_cnt != 16'd7; i++) tick;
    chk("ab_reach7", 72'(in_cnt), 72'(7));
    abort = 1'b1; src_valid = 1'b0;
    tick;
    abort = 1'b0;
    s_rl = n_rl;
    chk("ab_flush_rstn", 72'(proc_rstn), 72'(0));
    wait_idle(20, 1'b0);
    chk("ab_rstn_low", 72'(n_rl - s_rl), 72'(2));
    chk("ab_in_hold", 72'(in_cnt), 72'(7));
    chk("ab_done", 72'(n_done - s_done), 72'(0));
    chk("ab_frames", 72'(frame_cnt), 72'(5));
    src_valid = 1'b1;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("idle_abort", 72'(busy), 72'(0));
    pulse_start;
    chk("restart_in", 72'(in_cnt), 72'(0));
    chk("restart_out", 72'(out_cnt), 72'(0));
    chk("restart_busy", 72'(busy), 72'(1));
    wait_idle(100, 1'b0);
    chk("restart_frames", 72'(frame_cnt), 72'(6));
    chk("restart_out_cnt", 72'(out_cnt), 72'(16));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
